// File: rtl/press_pkg.sv
// Shared state encoding for the button press classifier.
package press_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } state_t;

endpackage

// File: rtl/press_classifier_hold_timer.sv
// Hold-duration counter with synchronous clear/enable and a terminal-count
// flag compared against a threshold supplied at runtime.
module hold_timer #(
  parameter int CNT_W = 21
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] threshold,
  output logic             terminal
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == threshold);

endmodule

// File: rtl/press_classifier.sv
// Turns the debounced button level into press/release/short/long/repeat pulses.
// Optional auto-repeat while held past the long threshold: define REPEAT_EN.
module press_classifier
  import press_pkg::*;
#(
  parameter int CNT_W         = 21,
  parameter int LONG_CYCLES   = 1_000_000,
  parameter int REPEAT_CYCLES = 200_000
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic press,
  output logic release_pulse,
  output logic short_click,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  localparam logic [CNT_W-1:0] LONG_TH   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_TH = CNT_W'(REPEAT_CYCLES - 1);

  state_t           state, next_state;
  logic             level_q;
  logic             rise, fall;
  logic             timer_clear, timer_enable, timer_terminal;
  logic [CNT_W-1:0] timer_threshold;
  logic             press_d, release_d, short_d, long_d, repeat_d;

  assign rise = level & ~level_q;
  assign fall = ~level & level_q;

  // One shared timer: the long threshold while HELD, the repeat period while LONG.
  assign timer_threshold = (state == HELD) ? LONG_TH : REPEAT_TH;

  hold_timer #(
    .CNT_W(CNT_W)
  ) u_hold_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (timer_clear),
    .enable   (timer_enable),
    .threshold(timer_threshold),
    .terminal (timer_terminal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      level_q <= 1'b0;
    end else begin
      state   <= next_state;
      level_q <= level;
    end
  end

  // Release is checked before the threshold so a fall on the terminal cycle is a short click.
  always_comb begin
    next_state   = state;
    timer_clear  = 1'b0;
    timer_enable = 1'b0;
    press_d      = 1'b0;
    release_d    = 1'b0;
    short_d      = 1'b0;
    long_d       = 1'b0;
    repeat_d     = 1'b0;
    case (state)
      IDLE: begin
        timer_clear = 1'b1;
        if (rise) begin
          next_state = HELD;
          press_d    = 1'b1;
        end
      end
      HELD: begin
        if (fall) begin
          next_state  = IDLE;
          timer_clear = 1'b1;
          release_d   = 1'b1;
          short_d     = 1'b1;
        end else if (timer_terminal) begin
          next_state  = LONG;
          timer_clear = 1'b1;
          long_d      = 1'b1;
        end else begin
          timer_enable = 1'b1;
        end
      end
      LONG: begin
        if (fall) begin
          next_state  = IDLE;
          timer_clear = 1'b1;
          release_d   = 1'b1;
        end else begin
`ifdef REPEAT_EN
          if (timer_terminal) begin
            timer_clear = 1'b1;
            repeat_d    = 1'b1;
          end else begin
            timer_enable = 1'b1;
          end
`else
          timer_clear = 1'b1;
`endif
        end
      end
      default: begin
        next_state  = IDLE;
        timer_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
      short_click   <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      press         <= press_d;
      release_pulse <= release_d;
      short_click   <= short_d;
      long_press    <= long_d;
      repeat_pulse  <= repeat_d;
    end
  end

  assign held = (state != IDLE);

endmodule

// File: tb/tb_press_classifier.sv
// Scoreboard bench for press_classifier with LONG_CYCLES=8, REPEAT_CYCLES=4;
// repeat expectations follow REPEAT_EN.
module tb_press_classifier;

  localparam logic [4:0] EV_PRESS = 5'b10000;
  localparam logic [4:0] EV_REL   = 5'b01000;
  localparam logic [4:0] EV_SHORT = 5'b00100;
  localparam logic [4:0] EV_LONG  = 5'b00010;
  localparam logic [4:0] EV_RPT   = 5'b00001;

  logic clk = 1'b0;
  logic reset;
  logic level;
  logic press, release_pulse, short_click, long_press, repeat_pulse, held;

  typedef struct {
    int         stamp;
    logic [4:0] vec;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   fails  = 0;
  int   s;

  press_classifier #(
    .CNT_W        (4),
    .LONG_CYCLES  (8),
    .REPEAT_CYCLES(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .level        (level),
    .press        (press),
    .release_pulse(release_pulse),
    .short_click  (short_click),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse),
    .held         (held)
  );

  always #5 clk = ~clk;

  // Edge index: the pulse produced by edge n is seen at the following negedge with cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic pushExpect(input int stamp, input logic [4:0] vec);
    exp_t e;
    e.stamp = stamp;
    e.vec   = vec;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic lvl, input int ncycles);
    level = lvl;
    repeat (ncycles) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [5:0] got, input logic [5:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", name, cyc, got, want);
    end
  endtask

  // Monitor: every nonzero pulse vector must match the oldest expected event and its cycle.
  always @(negedge clk) begin
    logic [4:0] obs;
    exp_t       e;
    obs = {press, release_pulse, short_click, long_press, repeat_pulse};
    if (obs !== 5'b00000 && !$isunknown(obs)) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_pulse at cycle %0d: got %b, expected none", cyc, obs);
      end else begin
        e = sb.pop_front();
        if (e.stamp != cyc || e.vec != obs) begin
          fails++;
          $display("[TB] FAIL pulse_match: got %b at cycle %0d, expected %b at cycle %0d",
                   obs, cyc, e.vec, e.stamp);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    level = 1'b0;

    $display("[TB] test 1: reset idle");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("reset_idle",
                  {held, press, release_pulse, short_click, long_press, repeat_pulse}, 6'b0);
    end
    reset = 1'b0;
    applyStimulus(1'b0, 2);
    checkOutput("idle_after_reset", {5'b0, held}, 6'b0);

    $display("[TB] test 2: short click");
    s = cyc + 1;
    pushExpect(s, EV_PRESS);
    pushExpect(s + 3, EV_REL | EV_SHORT);
    applyStimulus(1'b1, 3);
    checkOutput("held_during_click", {5'b0, held}, 6'b000001);
    applyStimulus(1'b0, 4);
    checkOutput("held_after_click", {5'b0, held}, 6'b0);

    $display("[TB] test 3/4: long hold");
    s = cyc + 1;
    pushExpect(s, EV_PRESS);
    pushExpect(s + 8, EV_LONG);
`ifdef REPEAT_EN
    pushExpect(s + 12, EV_RPT);
    pushExpect(s + 16, EV_RPT);
    pushExpect(s + 20, EV_RPT);
`endif
    pushExpect(s + 21, EV_REL);
    applyStimulus(1'b1, 21);
    checkOutput("held_long", {5'b0, held}, 6'b000001);
    applyStimulus(1'b0, 4);

    $display("[TB] test 5: fall on threshold cycle");
    s = cyc + 1;
    pushExpect(s, EV_PRESS);
    pushExpect(s + 8, EV_REL | EV_SHORT);
    applyStimulus(1'b1, 8);
    applyStimulus(1'b0, 4);

    $display("[TB] test 6: reset mid-hold");
    s = cyc + 1;
    pushExpect(s, EV_PRESS);
    applyStimulus(1'b1, 5);
    reset = 1'b1;
    applyStimulus(1'b1, 1);
    reset = 1'b0;
    checkOutput("held_cleared_by_reset", {5'b0, held}, 6'b0);
    pushExpect(s + 6, EV_PRESS);
    pushExpect(s + 14, EV_LONG);
`ifdef REPEAT_EN
    pushExpect(s + 18, EV_RPT);
`endif
    pushExpect(s + 20, EV_REL);
    applyStimulus(1'b1, 14);
    applyStimulus(1'b0, 4);
    checkOutput("held_final", {5'b0, held}, 6'b0);

    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL missing_pulses: got %0d left in scoreboard, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
